pipe_stage_skid_reg: RTL

//   Generic pipeline stage register: successor to the fixed per-stage registers (ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid_reg.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer.
// Optional perf counters under PIPE_STAGE_PERF_EN.
//
// Ports:
//   clock, reset (sync, active-high), flush (sync squash)
//   in_valid/in_ready/in_ctrl/in_data     upstream side
//   out_valid/out_ready/out_ctrl/out_data downstream side
//   stall_cnt, bubble_cnt                 only with PIPE_STAGE_PERF_EN
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_ready_q;

  logic in_fire, out_fire;
  logic ld_main_in, ld_main_skid, ld_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // Bubbles never carry control bits downstream.
  assign out_ctrl  = out_valid ? main_ctrl : {CTRL_W{1'b0}};
  assign out_data  = main_data;

  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_n    = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire & out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_n = FULL;
          ld_skid = 1'b1;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_n      = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    // Squash wins over any transfer; payload regs just hold.
    if (flush) begin
      state_n      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != FULL);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (ld_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (ld_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (ld_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid & ~out_ready & ~&stall_cnt)
        stall_cnt <= stall_cnt + 1'b1;
      if (~out_valid & ~&bubble_cnt)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
